upg_word_writer: RTL and testbench

UPG_WORD_WRITER -- requirements
Module: upg_word_writer

---
 rtl/upg_pkg.sv | 19 +
 rtl/upg_byte_packer.sv | 35 +++
 rtl/upg_word_writer.sv | 132 +++++++++++++
 tb/tb_upg_word_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// Shared constants and state encoding for the UART programmer word writer.
// The header and word geometry are fixed here so the packer and the FSM agree.
package upg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } upg_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = HDR_BYTES * 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/upg_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits [7:0].
// word/word_stb are combinational so the caller can register the finished word on the 4th byte.
module upg_byte_packer
  import upg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_stb
);

  localparam int unsigned SH_W = WORD_W - 8;
  localparam logic [BYTE_IDX_W-1:0] IDX_LAST = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q;
  // Only the first three bytes need storage; the fourth is taken straight from the input.
  logic [SH_W-1:0]       shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid) begin
      idx_q   <= idx_q + 1'b1;
      shift_q <= {byte_data, shift_q[SH_W-1:8]};
    end
  end

  assign word_stb = byte_valid && (idx_q == IDX_LAST);
  assign word     = {byte_data, shift_q};

endmodule

// File: rtl/upg_word_writer.sv
// UART image loader: a 2-byte little-endian word count, then count little-endian 32-bit words
// written to consecutive RAM addresses starting at 0.
module upg_word_writer
  import upg_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_n_i,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o,
  output upg_state_t        dbg_state_o
);

  // Handshake: rx_valid_i is a one-cycle strobe with no back-pressure; a byte is consumed in
  // the cycle it is presented or lost. upg_wen_o is a one-cycle strobe with adr/dat valid alongside.

  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  upg_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic              last_q;
  logic              err_q;
  logic              wen_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;

  logic [CNT_W-1:0]  hdr_count;
  logic              hdr_zero;
  logic              hdr_too_big;
  logic              last_word;
  logic              pack_valid;
  logic              busy;
  logic [31:0]       word;
  logic              word_stb;

  assign hdr_count   = {rx_data_i, count_q[7:0]};
  assign hdr_zero    = (hdr_count == '0);
  assign hdr_too_big = ({1'b0, hdr_count} > MAX_EXT);
  assign last_word   = (wcnt_q == count_q - ONE);

  upg_byte_packer u_packer (
    .clk        (upg_clk_i),
    .rst_n      (upg_rst_n_i),
    .clear      (start_i),
    .byte_valid (pack_valid),
    .byte_data  (rx_data_i),
    .word       (word),
    .word_stb   (word_stb)
  );

  always_comb begin
    state_d    = state_q;
    pack_valid = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_HDR_LO: begin
        busy = 1'b1;
        if (rx_valid_i) state_d = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        busy = 1'b1;
        if (rx_valid_i) state_d = (hdr_zero || hdr_too_big) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        busy = 1'b1;
        // Once the final word is captured, further bytes are dropped while its pulse goes out.
        pack_valid = rx_valid_i && !last_q;
        if (wen_q && last_q) state_d = ST_DONE;
      end
      default: ;
    endcase
    // A start in any state restarts the header; a byte arriving with it is discarded.
    if (start_i) begin
      state_d    = ST_HDR_LO;
      pack_valid = 1'b0;
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wcnt_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= 1'b0;
      if (word_stb) begin
        wen_q  <= 1'b1;
        adr_q  <= wcnt_q[ADDR_W-1:0];
        dat_q  <= word;
        wcnt_q <= wcnt_q + ONE;
        last_q <= last_word;
      end
      if (start_i) begin
        count_q <= '0;
        wcnt_q  <= '0;
        last_q  <= 1'b0;
        err_q   <= 1'b0;
      end else if (state_q == ST_HDR_LO && rx_valid_i) begin
        count_q[7:0] <= rx_data_i;
      end else if (state_q == ST_HDR_HI && rx_valid_i) begin
        count_q[CNT_W-1:8] <= rx_data_i;
        if (hdr_too_big) err_q <= 1'b1;
      end
    end
  end

  assign upg_wen_o   = wen_q;
  assign upg_adr_o   = adr_q;
  assign upg_dat_o   = dat_q;
  assign upg_done_o  = (state_q == ST_DONE);
  assign busy_o      = busy;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_upg_word_writer.sv
// Directed bench for upg_word_writer: a byte-stream model predicts every RAM write,
// and a per-cycle monitor checks pulses, data, addresses and done timing against it.
module tb_upg_word_writer;
  import upg_pkg::*;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 16384;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              wen;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat;
  logic              done;
  logic              busy;
  logic              err;
  upg_state_t        dbg_state;

  int total = 0;
  int bad   = 0;
  int n0;

  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] exp_adr_q[$];
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] got_adr_q[$];
  logic [31:0]       got_dat_q[$];
  bit                chk_done_edge = 1'b0;
  logic              prev_wen = 1'b0;
  logic              prev_done = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  upg_word_writer #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .start_i     (start),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .upg_wen_o   (wen),
    .upg_adr_o   (adr),
    .upg_dat_o   (dat),
    .upg_done_o  (done),
    .busy_o      (busy),
    .err_o       (err),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Model: the header gives the word count; every complete group of 4 bytes after it is one
  // word, up to that count, written at addresses 0,1,2,... Rejected headers produce nothing.
  task automatic model_stream();
    int cnt;
    int words;
    if (tx_q.size() < 2) return;
    cnt = int'(tx_q[0]) + 256 * int'(tx_q[1]);
    if (cnt == 0 || cnt > MAX_WORDS) return;
    words = (tx_q.size() - 2) / 4;
    if (words > cnt) words = cnt;
    for (int i = 0; i < words; i++) begin
      exp_adr_q.push_back(ADDR_W'(i));
      exp_q.push_back({tx_q[2+4*i+3], tx_q[2+4*i+2], tx_q[2+4*i+1], tx_q[2+4*i]});
    end
  endtask

  // driver tasks
  task automatic drive_tx(input int gap);
    while (tx_q.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = tx_q.pop_front();
      step();
      rx_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      step();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard / monitor: every write pulse must match the next predicted write
  always @(negedge clk) begin
    if (wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_wen adr=%0h dat=%0h", adr, dat);
      end else begin
        logic [ADDR_W-1:0] ea;
        logic [31:0] ed;
        ea = exp_adr_q.pop_front();
        ed = exp_q.pop_front();
        if (adr !== ea || dat !== ed) begin
          bad++;
          $display("FAIL wen_write got adr=%0h dat=%0h want adr=%0h dat=%0h", adr, dat, ea, ed);
        end
      end
      got_adr_q.push_back(adr);
      got_dat_q.push_back(dat);
      total++;
      if (prev_wen) begin
        bad++;
        $display("FAIL wen_width got=2+ cycles want=1 cycle");
      end
    end
    if (done && !prev_done && chk_done_edge) begin
      total++;
      if (!prev_wen) begin
        bad++;
        $display("FAIL done_timing got=no_wen_prev_cycle want=wen_prev_cycle");
      end
    end
    prev_wen  = wen;
    prev_done = done;
  end

  initial begin
    // reset state
    repeat (3) step();
    check("rst_wen", wen, 1'b0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat, 0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    step();

    // IDLE ignores bytes
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    drive_tx(0);
    repeat (2) step();
    check("idle_busy", busy, 1'b0);
    check("idle_state", dbg_state, ST_IDLE);

    // two-word image with idle gaps
    n0 = got_adr_q.size();
    chk_done_edge = 1'b1;
    pulse_start();
    check("start_busy", busy, 1'b1);
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_stream();
    drive_tx(1);
    wait_done("two_done", 20);
    check_drained("two_drained");
    check("two_adr0", got_adr_q[n0], 0);
    check("two_dat0", got_dat_q[n0], 32'h44332211);
    check("two_adr1", got_adr_q[n0+1], 1);
    check("two_dat1", got_dat_q[n0+1], 32'hDDCCBBAA);
    check("two_err", err, 1'b0);
    check("two_busy", busy, 1'b0);
    // DONE ignores bytes and outputs hold
    tx_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    drive_tx(0);
    repeat (2) step();
    check("hold_done", done, 1'b1);
    check("hold_adr", adr, 1);
    check("hold_dat", dat, 32'hDDCCBBAA);

    // zero-length header
    chk_done_edge = 1'b0;
    n0 = got_adr_q.size();
    pulse_start();
    check("zero_done_clr", done, 1'b0);
    tx_q = '{8'h00, 8'h00};
    model_stream();
    drive_tx(0);
    wait_done("zero_done", 5);
    repeat (3) step();
    check("zero_nowen", got_adr_q.size(), n0);
    check("zero_err", err, 1'b0);

    // oversize header
    tx_q = '{8'h01, 8'h41};
    pulse_start();
    model_stream();
    drive_tx(0);
    wait_done("big_done", 5);
    repeat (3) step();
    check("big_err", err, 1'b1);
    check("big_nowen", got_adr_q.size(), n0);
    pulse_start();
    check("big_err_clr", err, 1'b0);
    check("big_busy", busy, 1'b1);

    // back-to-back bytes, three words
    chk_done_edge = 1'b1;
    n0 = got_adr_q.size();
    pulse_start();
    tx_q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    model_stream();
    drive_tx(0);
    wait_done("b2b_done", 10);
    check_drained("b2b_drained");
    check("b2b_count", got_adr_q.size() - n0, 3);
    check("b2b_adr2", got_adr_q[n0+2], 2);
    check("b2b_dat2", got_dat_q[n0+2], 32'h0C0B0A09);

    // reset mid-word discards the partial word
    chk_done_edge = 1'b0;
    n0 = got_adr_q.size();
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'hE1, 8'hE2};
    model_stream();
    drive_tx(0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_nowen", got_adr_q.size(), n0);
    chk_done_edge = 1'b1;
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    model_stream();
    drive_tx(0);
    wait_done("rst_mid_done", 10);
    check_drained("rst_mid_drained");
    check("rst_mid_count", got_adr_q.size() - n0, 1);
    check("rst_mid_adr", got_adr_q[n0], 0);
    check("rst_mid_dat", got_dat_q[n0], 32'h04030201);

    // start during the write pulse of a completed word: pulse still issued
    chk_done_edge = 1'b0;
    n0 = got_adr_q.size();
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h91, 8'h92, 8'h93, 8'h94};
    model_stream();
    drive_tx(0);
    pulse_start();
    step();
    check_drained("abort_pending");
    check("abort_busy", busy, 1'b1);
    chk_done_edge = 1'b1;
    tx_q = '{8'h01, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    model_stream();
    drive_tx(0);
    wait_done("abort_done", 10);
    check_drained("abort_drained");
    check("abort_adr", got_adr_q[got_adr_q.size()-1], 0);
    check("abort_dat", got_dat_q[got_dat_q.size()-1], 32'hA4A3A2A1);

    // full-size image, incrementing bytes
    pulse_start();
    tx_q = '{8'h00, 8'h40};
    for (int k = 0; k < 4 * MAX_WORDS; k++) tx_q.push_back(k[7:0]);
    model_stream();
    drive_tx(0);
    wait_done("full_done", 10);
    repeat (4) step();
    check_drained("full_drained");
    check("full_last_adr", got_adr_q[got_adr_q.size()-1], 14'h3FFF);
    check("full_last_dat", got_dat_q[got_dat_q.size()-1], 32'hFFFEFDFC);
    check("full_err", err, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
